// File: rtl/i281_pkg.sv
// Shared constants and loader state type for the i281 code-memory loader.
package i281_pkg;

    localparam int unsigned CODE_ADDR_W = 6;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CODE_DEPTH  = 64;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WR,
        CK,
        FIN
    } loader_state_t;

endpackage

// File: rtl/codemem_loader.sv
// codemem_loader: assembles big-endian instructions from a byte stream and writes them
// to consecutive code-memory addresses, holding the CPU for the duration of the load.
// Optional trailing XOR checksum byte enabled by defining CODEMEM_LOADER_CKSUM_EN.
module codemem_loader #(
    parameter int unsigned ADDR_W = i281_pkg::CODE_ADDR_W,
    parameter int unsigned WORD_W = i281_pkg::INSTR_W,
    parameter int unsigned BYTE_W = i281_pkg::BYTE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              c1,
    output logic [ADDR_W-1:0] write_select,
    output logic [WORD_W-1:0] inp,
    output logic              cpu_hold,
    output logic              done,
    output logic              cksum_err
);
    import i281_pkg::*;

    // A count of zero means a full memory load.
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    loader_state_t   state;
    logic [ADDR_W:0] remaining;
    logic [ADDR_W:0] addr;
    logic            xfer_c;

`ifdef CODEMEM_LOADER_CKSUM_EN
    logic [BYTE_W-1:0] xsum;
`else
    assign cksum_err = 1'b0;
`endif

    // A byte moves only when the loader advertised ready on the previous edge.
    assign xfer_c = byte_valid & byte_ready;

    // Loader FSM with registered outputs; abort wins over every other event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            remaining    <= '0;
            addr         <= '0;
            byte_ready   <= 1'b0;
            c1           <= 1'b0;
            write_select <= '0;
            inp          <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
`ifdef CODEMEM_LOADER_CKSUM_EN
            xsum         <= '0;
            cksum_err    <= 1'b0;
`endif
        end else begin
            c1   <= 1'b0;
            done <= 1'b0;
            if (load_abort) begin
                state      <= IDLE;
                byte_ready <= 1'b0;
                cpu_hold   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_start) begin
                            remaining  <= (word_count == '0) ? FULL_CNT : word_count;
                            addr       <= '0;
                            cpu_hold   <= 1'b1;
                            byte_ready <= 1'b1;
`ifdef CODEMEM_LOADER_CKSUM_EN
                            xsum       <= '0;
                            cksum_err  <= 1'b0;
`endif
                            state      <= HI;
                        end
                    end
                    HI: begin
                        if (xfer_c) begin
                            inp[WORD_W-1:BYTE_W] <= byte_data;
`ifdef CODEMEM_LOADER_CKSUM_EN
                            xsum <= xsum ^ byte_data;
`endif
                            state <= LO;
                        end
                    end
                    LO: begin
                        if (xfer_c) begin
                            inp[BYTE_W-1:0] <= byte_data;
`ifdef CODEMEM_LOADER_CKSUM_EN
                            xsum <= xsum ^ byte_data;
`endif
                            byte_ready <= 1'b0;
                            state      <= WR;
                        end
                    end
                    WR: begin
                        // The write strobe is launched here so an abort in this cycle can cancel it.
                        c1           <= 1'b1;
                        write_select <= addr[ADDR_W-1:0];
                        addr         <= addr + ONE;
                        remaining    <= remaining - ONE;
                        if (remaining == ONE) begin
`ifdef CODEMEM_LOADER_CKSUM_EN
                            byte_ready <= 1'b1;
                            state      <= CK;
`else
                            state      <= FIN;
`endif
                        end else begin
                            byte_ready <= 1'b1;
                            state      <= HI;
                        end
                    end
                    CK: begin
`ifdef CODEMEM_LOADER_CKSUM_EN
                        if (xfer_c) begin
                            cksum_err  <= (byte_data != xsum);
                            byte_ready <= 1'b0;
                            state      <= FIN;
                        end
`else
                        state <= IDLE;
`endif
                    end
                    FIN: begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_codemem_loader.sv
// Testbench for codemem_loader: directed scenarios plus a randomized full load,
// checked against expected write lists derived from the byte stream.
module tb_codemem_loader;
    import i281_pkg::*;

    localparam int unsigned ADDR_W = CODE_ADDR_W;
    localparam int unsigned WORD_W = INSTR_W;

    logic              clock        = 1'b0;
    logic              reset_n      = 1'b0;
    logic              load_start   = 1'b0;
    logic              load_abort   = 1'b0;
    logic [ADDR_W:0]   word_count   = '0;
    logic              byte_valid   = 1'b0;
    logic [BYTE_W-1:0] byte_data    = '0;
    logic              byte_ready;
    logic              c1;
    logic [ADDR_W-1:0] write_select;
    logic [WORD_W-1:0] inp;
    logic              cpu_hold;
    logic              done;
    logic              cksum_err;

    codemem_loader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .load_abort   (load_abort),
        .word_count   (word_count),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .c1           (c1),
        .write_select (write_select),
        .inp          (inp),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .cksum_err    (cksum_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cnt  = 0;
    int done_cyc  = 0;
    int last_acc  = 0;

    always @(posedge clock) cyc = cyc + 1;

    // Observer of the code-memory write port and done pulses.
    always @(negedge clock) begin
        if (c1 === 1'b1) begin
            wr_addr.push_back(int'(write_select));
            wr_data.push_back(int'(inp));
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic idle(input int k);
        byte_valid = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    task automatic start(input int cnt);
        word_count = (ADDR_W+1)'(cnt);
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
        last_acc = cyc;
        @(negedge clock);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        byte_valid = 1'b0;
        while (done_cnt < target && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
        logic [7:0] x;
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        return x;
    endfunction

    // Expected writes: word i at address i, big-endian from bytes 2i and 2i+1.
    task automatic check_writes(input string tag, input logic [7:0] q[$], input int n);
        chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
            chk({tag, "_data"}, 32'(wr_data[i]), 32'({q[2*i], q[2*i+1]}));
        end
    endtask

    task automatic do_load(input int cnt, input logic [7:0] q[$], input int maxgap);
        start(cnt);
        foreach (q[i]) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            send_byte(q[i]);
        end
        byte_valid = 1'b0;
`ifdef CODEMEM_LOADER_CKSUM_EN
        send_byte(xor_of(q));
        byte_valid = 1'b0;
`endif
    endtask

    initial begin
        logic [7:0] q[$];
        int first_acc;
        int d0;

        // Reset values while reset is held.
        #2;
        chk("rst_c1", 32'(c1), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wsel", 32'(write_select), 32'd0);
        chk("rst_inp", 32'(inp), 32'd0);
        chk("rst_cksum", 32'(cksum_err), 32'd0);
        #10 reset_n = 1'b1;
        @(negedge clock);

        // Two words back-to-back: timing and data.
        clear_log();
        q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        d0 = done_cnt;
        start(2);
        chk("t1_hold", 32'(cpu_hold), 32'd1);
        chk("t1_ready", 32'(byte_ready), 32'd1);
        send_byte(q[0]);
        first_acc = last_acc;
        send_byte(q[1]);
        send_byte(q[2]);
        send_byte(q[3]);
        byte_valid = 1'b0;
`ifdef CODEMEM_LOADER_CKSUM_EN
        send_byte(xor_of(q));
        byte_valid = 1'b0;
`endif
        wait_done(d0 + 1);
        check_writes("t1", q, 2);
        if (wr_cyc.size() == 2) begin
            chk("t1_lat", 32'(wr_cyc[1] - first_acc), 32'd6);
`ifndef CODEMEM_LOADER_CKSUM_EN
            chk("t1_done_lat", 32'(done_cyc - wr_cyc[1]), 32'd1);
`endif
        end
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_hold_end", 32'(cpu_hold), 32'd0);

        // Full load (count 0) with random stalls.
        clear_log();
        q.delete();
        for (int i = 0; i < 128; i++) q.push_back(8'($urandom));
        d0 = done_cnt;
        start(0);
        foreach (q[i]) begin
            idle($urandom_range(0, 3));
            if (i == 64) chk("t2_hold_mid", 32'(cpu_hold), 32'd1);
            send_byte(q[i]);
        end
        byte_valid = 1'b0;
`ifdef CODEMEM_LOADER_CKSUM_EN
        send_byte(xor_of(q));
`endif
        wait_done(d0 + 1);
        check_writes("t2", q, 64);
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t2_hold_end", 32'(cpu_hold), 32'd0);

        // Abort during the third WR: two writes, no done, then a fresh load.
        clear_log();
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        d0 = done_cnt;
        start(5);
        foreach (q[i]) send_byte(q[i]);
        byte_valid = 1'b0;
        load_abort = 1'b1;
        @(negedge clock);
        load_abort = 1'b0;
        repeat (6) @(negedge clock);
        check_writes("t3", q, 2);
        chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t3_hold", 32'(cpu_hold), 32'd0);
        chk("t3_ready", 32'(byte_ready), 32'd0);
        clear_log();
        q = '{8'h5A, 8'hC3};
        do_load(1, q, 1);
        wait_done(d0 + 1);
        check_writes("t3b", q, 1);

        // load_start mid-load is ignored.
        clear_log();
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        d0 = done_cnt;
        start(3);
        send_byte(q[0]);
        send_byte(q[1]);
        byte_valid = 1'b0;
        word_count = (ADDR_W+1)'(1);
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        for (int i = 2; i < 6; i++) send_byte(q[i]);
        byte_valid = 1'b0;
`ifdef CODEMEM_LOADER_CKSUM_EN
        send_byte(xor_of(q));
`endif
        wait_done(d0 + 1);
        check_writes("t4", q, 3);

        // Asynchronous reset while in LO.
        clear_log();
        start(2);
        send_byte(8'h55);
        byte_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("t5_c1", 32'(c1), 32'd0);
        chk("t5_ready", 32'(byte_ready), 32'd0);
        chk("t5_hold", 32'(cpu_hold), 32'd0);
        chk("t5_wsel", 32'(write_select), 32'd0);
        chk("t5_inp", 32'(inp), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clock);
        repeat (3) @(negedge clock);
        chk("t5_nwrites", 32'(wr_addr.size()), 32'd0);
        clear_log();
        q = '{8'hDE, 8'hAD};
        d0 = done_cnt;
        do_load(1, q, 0);
        wait_done(d0 + 1);
        check_writes("t5b", q, 1);

`ifdef CODEMEM_LOADER_CKSUM_EN
        // Checksum good, then bad (sticky), then cleared by the next start.
        d0 = done_cnt;
        start(1);
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'hFF);
        wait_done(d0 + 1);
        chk("ck_good", 32'(cksum_err), 32'd0);
        start(1);
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'h00);
        wait_done(d0 + 2);
        chk("ck_bad", 32'(cksum_err), 32'd1);
        repeat (5) @(negedge clock);
        chk("ck_sticky", 32'(cksum_err), 32'd1);
        start(1);
        chk("ck_clear", 32'(cksum_err), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        wait_done(d0 + 3);
        chk("ck_good2", 32'(cksum_err), 32'd0);
`else
        chk("ck_tied", 32'(cksum_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
